// File: rtl/option_pipe.sv
// option_pipe: valid/ready retiming pipeline of DEPTH registered stages.
// Each stage holds an optional value (valid bit + DATA_WIDTH payload).
// Empty stages always accept, so bubbles collapse even under backpressure.
// The ready path is combinational through every stage, so a full pipe
// can accept a new item in the same cycle it drains one.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous active-high reset (clears valid and data)
//   flush      synchronous clear of all valid bits (data registers hold)
//   in_valid   upstream item present
//   in_data    upstream payload
//   in_ready   stage 0 can accept this cycle
//   out_valid  last stage holds an item
//   out_data   last-stage payload (meaningful only when out_valid=1)
//   out_ready  downstream accepts this cycle
//   occupancy  registered count of valid stages

// One pipeline stage: loads its source whenever its advance bit is set.
module option_stage #(
  parameter int DATA_WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  adv,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid_nxt
);
  // Exposed so the top can count next-cycle occupancy without a lag.
  always_comb begin
    valid_nxt = valid;
    if (reset || flush) valid_nxt = 1'b0;
    else if (adv)       valid_nxt = src_valid;
  end

  always_ff @(posedge clock) begin
    valid <= valid_nxt;
    // Data follows the source even when the source is empty; flush only
    // drops the valid bits.
    if (reset)             data <= '0;
    else if (adv && !flush) data <= src_data;
  end
endmodule

module option_pipe #(
  parameter int DATA_WIDTH = 3,
  parameter int DEPTH      = 4,
  parameter int OCC_WIDTH  = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [OCC_WIDTH-1:0]  occupancy
);
  logic [DEPTH-1:0]                 vld_pipe;
  logic [DEPTH-1:0]                 vld_nxt;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] dat_pipe;
  logic [DEPTH:0]                   adv;
  logic [OCC_WIDTH-1:0]             occ_nxt;

  // Advance chain from the output end: a stage moves if it is empty or
  // the stage after it moves.
  always_comb begin
    adv        = '0;
    adv[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) adv[k] = !vld_pipe[k] | adv[k+1];
  end

  assign in_ready  = adv[0] & !flush & !reset;
  assign out_valid = vld_pipe[DEPTH-1];
  assign out_data  = dat_pipe[DEPTH-1];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic                  src_v;
    logic [DATA_WIDTH-1:0] src_d;
    if (k == 0) begin : g_head
      assign src_v = in_valid;
      assign src_d = in_data;
    end else begin : g_body
      assign src_v = vld_pipe[k-1];
      assign src_d = dat_pipe[k-1];
    end

    option_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .adv       (adv[k]),
      .src_valid (src_v),
      .src_data  (src_d),
      .valid     (vld_pipe[k]),
      .data      (dat_pipe[k]),
      .valid_nxt (vld_nxt[k])
    );
  end

  // Popcount of the next valid vector so occupancy tracks the stages
  // in the same cycle they change.
  always_comb begin
    occ_nxt = '0;
    for (int k = 0; k < DEPTH; k++) occ_nxt = occ_nxt + OCC_WIDTH'(vld_nxt[k]);
  end

  always_ff @(posedge clock) occupancy <= occ_nxt;
endmodule
